bist_sequencer: RTL
===================

# bist_sequencer

Built-in self-test controller that sequences the team's `LFSR` pattern generator against a circuit under test (CUT). On `start` it loads the seed and polynomial into the LFSR and steps it for a programmed number of patterns. It compacts the CUT responses into an internal MISR, compares the final signature with a golden value, and reports pass/fail. It sits between the CPU-facing test registers and the LFSR/CUT pair.

## Interface
- `N`, 8, LFSR pattern width
- `W`, 8, CUT response / signature width
- `CNT_W`, 16, pattern counter width
- `CUT_LAT`, 0, CUT response latency in cycles; legal range 0..7
- `MISR_POLY`, 8'hB8, MISR feedback taps, `W` bits; bit `W-1` unused
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a test; sampled only in IDLE
- `pat_count`  in  CNT_W  number of patterns to apply; latched on start
- `seed_in`  in  N  LFSR seed; latched on start
- `poly_in`  in  N  LFSR polynomial; latched on start
- `golden`  in  W  expected signature; latched on start
- `cut_resp`  in  W  CUT response
- `lfsr_rst`  out  1  active-high seed-load pulse to the LFSR
- `lfsr_en`  out  1  LFSR step enable
- `lfsr_seed`  out  N  registered seed to the LFSR
- `lfsr_poly`  out  N  registered polynomial to the LFSR
- `busy`  out  1  high from SEED through COMPARE
- `done`  out  1  one-cycle pulse when the result is valid
- `pass`  out  1  signature == golden; held until the next start
- `signature`  out  W  final MISR value; held until the next start

## Operation
- States and transitions:
  - IDLE -> SEED when `start` is 1.
  - SEED -> RUN when `pat_count` != 0.
  - SEED -> FLUSH when `pat_count` == 0.
  - RUN -> FLUSH after exactly `pat_count` cycles.
  - FLUSH -> COMPARE after `CUT_LAT` cycles (zero cycles when `CUT_LAT` = 0, i.e. FLUSH is skipped and RUN/SEED go straight to COMPARE).
  - COMPARE -> IDLE.
- IDLE:
  - `busy` = 0, `lfsr_en` = 0, `lfsr_rst` = 0.
  - On `start`: latch `pat_count`, `seed_in`, `poly_in`, `golden` into internal registers and onto `lfsr_seed`/`lfsr_poly`.
  - Clear the MISR, clear the counter, clear `pass`.
- SEED (1 cycle):
  - `lfsr_rst` = 1, so the LFSR output equals the seed in the following cycle.
- RUN:
  - `lfsr_en` = 1 every cycle.
  - The pattern counter increments; the state exits when the counter reaches `pat_count` - 1.
  - In RUN cycle k (k from 0), the LFSR output is pattern k; pattern 0 is the seed.
- Capture:
  - `cap` = `lfsr_en` delayed by `CUT_LAT` cycles through a shift register cleared by reset and in SEED.
  - When `cap` is 1, the MISR updates:
    - `sig[W-1]` <= `sig[0]` ^ `cut_resp[W-1]`
    - `sig[i]` <= (`sig[0]` & `MISR_POLY[i]`) ^ `sig[i+1]` ^ `cut_resp[i]`, for i < W-1
  - Exactly `pat_count` captures occur per test.
- COMPARE (1 cycle):
  - `signature` <= `sig`, `pass` <= (`sig` == latched golden), `done` = 1 in the cycle after.
- Boundary conditions:
  - `start` while busy is ignored; the latched inputs are not disturbed.
  - `start` held high continuously starts back-to-back tests; IDLE lasts 1 cycle.
  - `pat_count` = 0: no LFSR steps, no captures, signature = 0, pass = (`golden` == 0).
  - The counter is `CNT_W` bits wide and never wraps; the maximum is 2^CNT_W - 1 patterns.
  - Changes to `seed_in`/`poly_in`/`golden` mid-test have no effect.
- Reset (`rst` = 0), at any time including mid-RUN:
  - State goes to IDLE.
  - All outputs go to 0: `lfsr_rst`, `lfsr_en`, `lfsr_seed`, `lfsr_poly`, `busy`, `done`, `pass`, `signature`.
  - MISR, counter and capture pipe are cleared.
  - The LFSR itself is not reset; the next test reseeds it.

## Timing
- All outputs are registered; none are combinational paths from inputs.
- Cycle `start` is sampled = t:
  - t+1: SEED, `lfsr_rst` = 1.
  - t+2 .. t+1+P: RUN, where P = `pat_count`.
  - Then FLUSH for `CUT_LAT` cycles, then COMPARE.
  - `done` = 1 at t+3+P+`CUT_LAT`.
- `busy` rises at t+1 and falls together with the `done` pulse.
- `pass`/`signature` become valid in the same cycle as `done`.

## Test plan
- `CUT_LAT` = 0, `cut_resp` tied to the LFSR output, seed 0x01, poly 0x1D, `pat_count` 1, golden 0x01 -> `signature` 0x01, `pass` = 1, `done` at t+4.
- Same setup with `pat_count` 2 (patterns 0x01, 0x9D), golden 0x25 -> `signature` 0x25, `pass` = 1; with golden 0x24 -> `pass` = 0.
- `pat_count` 0, golden 0x00 -> no `lfsr_en` pulses, `signature` 0x00, `pass` = 1, `done` at t+3.
- `CUT_LAT` = 3, `pat_count` 5 -> exactly 5 `cap` cycles, the first 3 cycles after the first `lfsr_en`; `done` at t+11.
- Pulse `start` during RUN -> ignored, result identical to an undisturbed run; assert `rst` = 0 mid-RUN -> all outputs 0 immediately, and a new test after release gives a correct signature.
- Hold `start` high -> back-to-back tests, `busy` low for exactly 1 cycle between them, identical signatures.

Source files
------------

// File: rtl/bist_sequencer.sv
// BIST sequencer: seeds and steps an external LFSR, compacts the CUT responses
// into a MISR and compares the final signature against a latched golden value.
module bist_sequencer #(
  parameter int N = 8,
  parameter int W = 8,
  parameter int CNT_W = 16,
  parameter int CUT_LAT = 0,
  parameter logic [W-1:0] MISR_POLY = 8'hB8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] pat_count,
  input  logic [N-1:0]     seed_in,
  input  logic [N-1:0]     poly_in,
  input  logic [W-1:0]     golden,
  input  logic [W-1:0]     cut_resp,
  output logic             lfsr_rst,
  output logic             lfsr_en,
  output logic [N-1:0]     lfsr_seed,
  output logic [N-1:0]     lfsr_poly,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [W-1:0]     signature
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEED    = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] FLUSH   = 3'd3;
  localparam logic [2:0] COMPARE = 3'd4;

  // With no CUT latency the flush phase disappears entirely.
  localparam logic [2:0] AFTER_RUN = (CUT_LAT == 0) ? COMPARE : FLUSH;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((CUT_LAT > 0) ? CUT_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pc_q;
  logic [W-1:0]     golden_q;
  logic [W-1:0]     sig;
  logic             cap;
  logic             launch;

  function automatic logic [W-1:0] misr_next(input logic [W-1:0] s, input logic [W-1:0] r);
    logic [W-1:0] n;
    n[W-1] = s[0] ^ r[W-1];
    for (int i = 0; i < W - 1; i++) begin
      n[i] = (s[0] & MISR_POLY[i]) ^ s[i+1] ^ r[i];
    end
    return n;
  endfunction

  assign launch = (state == IDLE) && start;

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = SEED;
        else       next_state = IDLE;
      end
      SEED: begin
        if (pc_q != {CNT_W{1'b0}}) next_state = RUN;
        else                       next_state = AFTER_RUN;
      end
      RUN: begin
        if (cnt == pc_q - CNT_ONE) next_state = AFTER_RUN;
        else                       next_state = RUN;
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) next_state = COMPARE;
        else                   next_state = FLUSH;
      end
      COMPARE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register and control outputs registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lfsr_rst <= 1'b0;
      lfsr_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= next_state;
      lfsr_rst <= (next_state == SEED);
      lfsr_en  <= (next_state == RUN);
      busy     <= (next_state != IDLE);
      done     <= (state == COMPARE);
    end
  end

  // Shared phase counter: pattern index in RUN, latency count in FLUSH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {CNT_W{1'b0}};
    end else begin
      case (state)
        RUN, FLUSH: begin
          if (next_state == state) cnt <= cnt + CNT_ONE;
          else                     cnt <= {CNT_W{1'b0}};
        end
        default: cnt <= {CNT_W{1'b0}};
      endcase
    end
  end

  // Test parameters captured on start only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= {CNT_W{1'b0}};
      golden_q  <= {W{1'b0}};
      lfsr_seed <= {N{1'b0}};
      lfsr_poly <= {N{1'b0}};
    end else if (launch) begin
      pc_q      <= pat_count;
      golden_q  <= golden;
      lfsr_seed <= seed_in;
      lfsr_poly <= poly_in;
    end else begin
      pc_q      <= pc_q;
      golden_q  <= golden_q;
      lfsr_seed <= lfsr_seed;
      lfsr_poly <= lfsr_poly;
    end
  end

  // Capture strobe follows lfsr_en by the CUT latency
  generate
    if (CUT_LAT == 0) begin : g_no_lat
      assign cap = lfsr_en;
    end else begin : g_lat
      logic [CUT_LAT-1:0] pipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pipe <= {CUT_LAT{1'b0}};
        end else if (state == SEED) begin
          pipe <= {CUT_LAT{1'b0}};
        end else begin
          pipe[0] <= lfsr_en;
          for (int j = 1; j < CUT_LAT; j++) pipe[j] <= pipe[j-1];
        end
      end
      assign cap = pipe[CUT_LAT-1];
    end
  endgenerate

  // MISR compaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig <= {W{1'b0}};
    end else if (launch) begin
      sig <= {W{1'b0}};
    end else if (cap) begin
      sig <= misr_next(sig, cut_resp);
    end else begin
      sig <= sig;
    end
  end

  // Result registers, valid alongside done and held until the next start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass      <= 1'b0;
      signature <= {W{1'b0}};
    end else if (launch) begin
      pass      <= 1'b0;
      signature <= signature;
    end else if (state == COMPARE) begin
      pass      <= (sig == golden_q);
      signature <= sig;
    end else begin
      pass      <= pass;
      signature <= signature;
    end
  end

endmodule
